// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: "101" preamble, DATA_W payload bits, two-bit low gap.
// Feeds the single-bit line of downstream 101 sequence detectors.
module serial_pattern_tx #(
  parameter int DATA_W           = 8,
  parameter int MSB_FIRST        = 1,
  parameter     FSM_ENCODING_VAL = "one_hot"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  // A word transfers on a rising edge where in_valid && in_ready; in_ready is
  // high only in IDLE outside reset, and in_valid elsewhere is left pending.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_A = 3'd1,
    PRE_B = 3'd2,
    PRE_C = 3'd3,
    DATA  = 3'd4,
    GAP   = 3'd5
  } state_t;

  (* fsm_encoding = FSM_ENCODING_VAL *) state_t state;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              gap_cnt;

  function automatic logic head(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign in_ready = (state == IDLE) && !rst;

  // sout is loaded on the same edge as the state change, so it always shows
  // the bit belonging to the state currently held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      gap_cnt <= 1'b0;
      sout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sout <= 1'b0;
          busy <= 1'b0;
          if (in_valid && in_ready) begin
            shreg <= in_data;
            cnt   <= '0;
            sout  <= 1'b1;
            busy  <= 1'b1;
            state <= PRE_A;
          end
        end
        PRE_A: begin
          sout  <= 1'b0;
          state <= PRE_B;
        end
        PRE_B: begin
          sout  <= 1'b1;
          state <= PRE_C;
        end
        PRE_C: begin
          sout  <= head(shreg);
          shreg <= advance(shreg);
          cnt   <= '0;
          state <= DATA;
        end
        DATA: begin
          if (cnt == LAST) begin
            sout    <= 1'b0;
            gap_cnt <= 1'b0;
            state   <= GAP;
          end else begin
            cnt   <= cnt + 1'b1;
            sout  <= head(shreg);
            shreg <= advance(shreg);
          end
        end
        GAP: begin
          sout <= 1'b0;
          if (gap_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            gap_cnt <= 1'b1;
          end
        end
        default: begin
          sout  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: MSB-first and LSB-first instances on shared
// stimulus, a scoreboard of expected line bits, and a 101 detector model.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, sout, busy, done;
  logic       in_ready_l, sout_l, busy_l, done_l;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_l_q[$];

  // 101 Moore detector model on the MSB-first line
  int det_cnt = 0;
  int det_st = 0;

  typedef struct {
    logic [7:0] data;
    int         det;
  } vec_t;
  vec_t tbl[5];

  serial_pattern_tx #(.DATA_W(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sout(sout), .busy(busy), .done(done)
  );

  serial_pattern_tx #(.DATA_W(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .sout(sout_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      det_st = 0;
    end else begin
      case (det_st)
        0: nxt = sout ? 1 : 0;
        1: nxt = sout ? 1 : 2;
        2: nxt = sout ? 3 : 0;
        default: nxt = sout ? 1 : 2;
      endcase
      det_st = nxt;
      if (nxt == 3) det_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (busy) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else chk("sout", {31'd0, sout}, {31'd0, exp_q.pop_front()});
      end else begin
        chk("idle_sout", {31'd0, sout}, 32'd0);
      end
      if (busy_l) begin
        if (exp_l_q.size() == 0) chk("sb_lsb_empty", 32'd0, 32'd1);
        else chk("sout_lsb", {31'd0, sout_l}, {31'd0, exp_l_q.pop_front()});
      end
    end
  end

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_l_q.push_back(1'b1); exp_l_q.push_back(1'b0); exp_l_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[7-i]);
      exp_l_q.push_back(d[i]);
    end
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_l_q.push_back(1'b0); exp_l_q.push_back(1'b0);
  endtask

  // Called at a negedge; returns right after the accept posedge (end of cycle 0).
  task automatic start_frame(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_wait", {31'd0, ok}, 32'd1);
    push_frame(d);
    @(posedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit toggle);
    start_frame(d);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (toggle && k <= 12) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom_range(0, 255));
      end else begin
        in_valid = 1'b0;
      end
      if (k <= 13) begin
        chk("busy_frame", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
      end else begin
        chk("done_cycle", {31'd0, done}, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("ready_end", {31'd0, in_ready}, 32'd1);
        chk("done_lsb", {31'd0, done_l}, 32'd1);
      end
    end
  endtask

  initial begin
    int base, d1, d2, nd;
    tbl[0] = '{data: 8'hA5, det: 3};
    tbl[1] = '{data: 8'h00, det: 1};
    tbl[2] = '{data: 8'h05, det: 2};
    tbl[3] = '{data: 8'hFF, det: 1};
    tbl[4] = '{data: 8'h01, det: 1};

    // Reset held for 3 cycles, outputs quiet and in_ready low throughout
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sout", {31'd0, sout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;
    @(negedge clk);

    // Table-driven frames with loopback detector counts
    foreach (tbl[i]) begin
      base = det_cnt;
      run_frame(tbl[i].data, 1'b0);
      chk($sformatf("det_%02h", tbl[i].data), det_cnt - base, tbl[i].det);
      @(negedge clk);
    end

    // Input toggled while busy must not disturb the payload
    run_frame(8'hA5, 1'b1);
    @(negedge clk);

    // Back-to-back: in_valid held high, FF then 00
    nd = 0; d1 = -1; d2 = -1;
    start_frame(8'hFF);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) in_data = 8'h00;
      if (done) begin
        nd++;
        if (nd == 1) d1 = k; else d2 = k;
      end
      if (k == 14) begin
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        push_frame(8'h00);
      end
      if (k == 15) begin
        in_valid = 1'b0;
        chk("b2b_pre_a_busy", {31'd0, busy}, 32'd1);
        chk("b2b_pre_a_sout", {31'd0, sout}, 32'd1);
      end
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_first_done", d1, 14);
    chk("b2b_spacing", d2 - d1, 14);

    // Reset asserted in cycle 6 of an A5 frame aborts it
    mon_en = 1'b0;
    start_frame(8'hA5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sout", {31'd0, sout}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    nd = 0;
    for (int k = 8; k <= 24; k++) begin
      @(negedge clk);
      if (done) nd++;
      chk("abort_quiet", {31'd0, sout}, 32'd0);
    end
    chk("abort_no_done", nd, 0);
    exp_q.delete();
    exp_l_q.delete();

    // One more frame after the abort, LSB-ordered payload 01 checked by scoreboard
    mon_en = 1'b1;
    run_frame(8'h01, 1'b0);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_lsb_drained", exp_l_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
